// File: rtl/request_manager_if.sv
// Signal bundle between the elevator request manager and its neighbours.
// The slave side is the request manager itself; the master side is whatever
// drives the sensors and buttons and consumes the decoded floor and target.
interface request_manager_if;
    // Inputs into the request manager
    logic [7:0] piso;          // raw floor-sensor bus, two bits per floor
    logic [3:0] peticion;      // hall-call buttons
    logic [3:0] seleccion;     // car buttons
    logic       puerta;        // door-open sensor

    // Outputs from the request manager
    logic [1:0] floor_idx;     // last aligned floor
    logic       at_floor;      // exactly aligned at floor_idx
    logic       between;       // between floor_idx and a neighbour
    logic       sensor_err;    // filtered pattern is not a legal position
    logic [3:0] pending;       // latched outstanding requests
    logic [1:0] target;        // next floor to serve
    logic       target_valid;  // at least one request outstanding
    logic       dir_up;        // SCAN direction, 1 = up
    logic       arrived;       // one-cycle pulse on arrival at a requested floor

    modport master (
        output piso, peticion, seleccion, puerta,
        input  floor_idx, at_floor, between, sensor_err,
        input  pending, target, target_valid, dir_up, arrived
    );

    modport slave (
        input  piso, peticion, seleccion, puerta,
        output floor_idx, at_floor, between, sensor_err,
        output pending, target, target_valid, dir_up, arrived
    );
endinterface

// File: rtl/request_manager.sv
// Upstream stage of the elevator controller: debounces the floor-sensor bus,
// decodes it into a floor position, latches call/car buttons into a pending
// mask and picks the next target floor with a SCAN (keep-direction) policy.
module request_manager #(
    parameter int NFLOORS = 4,    // fixed at 4; sensor bus is 2*NFLOORS bits
    parameter int FILT    = 2     // stable samples needed to accept a pattern (1..15)
) (
    input  logic              clk,
    input  logic              rst,
    request_manager_if.slave  bus
);

    localparam int          NF     = NFLOORS;
    localparam logic [3:0]  FILT_C = 4'(FILT);

    // ------------------------------------------------------------------
    // Sensor filter state
    // ------------------------------------------------------------------
    logic [7:0] sample_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [7:0] filt_q;

    // ------------------------------------------------------------------
    // Decoded position and request state
    // ------------------------------------------------------------------
    logic [1:0]    floor_idx_q, floor_idx_d;
    logic          at_floor_q,  at_floor_d;
    logic          between_q,   between_d;
    logic          sensor_err_q, sensor_err_d;
    logic [NF-1:0] pending_q,   pending_d;
    logic [NF-1:0] clr;
    logic [1:0]    target_q,    target_d;
    logic          target_valid_q, target_valid_d;
    logic          dir_up_q,    dir_up_d;
    logic          arrived_q,   arrived_d;
    logic          served_q,    served_d;
    logic          new_align;

    // Pattern match vectors
    logic [NF-1:0] align_match;
    logic [NF-2:0] btw_match;
    logic [1:0]    align_idx;

    // SCAN helper vectors
    logic [NF-1:0] above;
    logic [NF-1:0] below;
    logic [1:0]    lo_above;
    logic [1:0]    hi_below;

    // Run-length counter: saturates at FILT so a long stable stretch keeps
    // reloading the same pattern rather than wrapping.
    always_comb begin
        if (bus.piso == sample_q) begin
            cnt_d = (cnt_q >= FILT_C) ? cnt_q : cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd1;
        end
    end

    // Sample register, run counter and filtered pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 8'h00;
            cnt_q    <= 4'd0;
            filt_q   <= 8'h00;
        end else begin
            sample_q <= bus.piso;
            cnt_q    <= cnt_d;
            if (cnt_d >= FILT_C) begin
                filt_q <= bus.piso;
            end
        end
    end

    // Legal-pattern comparators: aligned at k is 2'b11 at bits [2k+1:2k],
    // between k and k+1 is the same pair shifted up by one bit.
    genvar gi;
    generate
        for (gi = 0; gi < NF; gi++) begin : g_align
            localparam logic [7:0] ALIGN_PAT = 8'h03 << (2 * gi);
            assign align_match[gi] = (filt_q == ALIGN_PAT);
        end
        for (gi = 0; gi < NF - 1; gi++) begin : g_btw
            localparam logic [7:0] BTW_PAT = 8'h06 << (2 * gi);
            assign btw_match[gi] = (filt_q == BTW_PAT);
        end
        for (gi = 0; gi < NF; gi++) begin : g_scan
            assign above[gi] = pending_q[gi] && (2'(gi) > floor_idx_q);
            assign below[gi] = pending_q[gi] && (2'(gi) < floor_idx_q);
            assign clr[gi]   = at_floor_q && bus.puerta && (floor_idx_q == 2'(gi));
        end
    endgenerate

    // One-hot to index for the aligned floor, and priority picks for SCAN
    always_comb begin
        align_idx = 2'd0;
        lo_above  = 2'd0;
        hi_below  = 2'd0;
        for (int i = 0; i < NF; i++) begin
            if (align_match[i]) align_idx = 2'(i);
        end
        for (int i = NF - 1; i >= 0; i--) begin
            if (above[i]) lo_above = 2'(i);
        end
        for (int i = 0; i < NF; i++) begin
            if (below[i]) hi_below = 2'(i);
        end
    end

    // Position decode; floor_idx only moves on an exact alignment
    always_comb begin
        at_floor_d   = |align_match;
        between_d    = !at_floor_d && (|btw_match);
        sensor_err_d = !at_floor_d && !between_d;
        floor_idx_d  = at_floor_d ? align_idx : floor_idx_q;
    end

    // Request latch: a door-open clear at the current floor beats a new press
    always_comb begin
        pending_d = (pending_q | bus.peticion | bus.seleccion) & ~clr;
    end

    // Arrival pulse: first cycle that alignment and a pending request at that
    // floor are both visible; 'served' blocks repeats until alignment is lost
    // or a different floor is reached.
    always_comb begin
        new_align = at_floor_d && (!at_floor_q || (floor_idx_d != floor_idx_q));
        arrived_d = at_floor_d && pending_d[floor_idx_d] && (new_align || !served_q);
        served_d  = at_floor_d && (arrived_d || (!new_align && served_q));
    end

    // SCAN target selection. Reversal and the serve-here case are only
    // considered while aligned; between floors the target can only move
    // further along the current direction.
    always_comb begin
        target_d       = target_q;
        dir_up_d       = dir_up_q;
        target_valid_d = |pending_q;
        if (dir_up_q && (|above)) begin
            target_d = lo_above;
        end else if (!dir_up_q && (|below)) begin
            target_d = hi_below;
        end else if (at_floor_q) begin
            if (|above) begin
                dir_up_d = 1'b1;
                target_d = lo_above;
            end else if (|below) begin
                dir_up_d = 1'b0;
                target_d = hi_below;
            end else if (pending_q[floor_idx_q]) begin
                target_d = floor_idx_q;
            end
        end
    end

    // Registered decode, request and target state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            floor_idx_q    <= 2'd0;
            at_floor_q     <= 1'b0;
            between_q      <= 1'b0;
            sensor_err_q   <= 1'b0;
            pending_q      <= '0;
            target_q       <= 2'd0;
            target_valid_q <= 1'b0;
            dir_up_q       <= 1'b1;
            arrived_q      <= 1'b0;
            served_q       <= 1'b0;
        end else begin
            floor_idx_q    <= floor_idx_d;
            at_floor_q     <= at_floor_d;
            between_q      <= between_d;
            sensor_err_q   <= sensor_err_d;
            pending_q      <= pending_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            dir_up_q       <= dir_up_d;
            arrived_q      <= arrived_d;
            served_q       <= served_d;
        end
    end

    assign bus.floor_idx    = floor_idx_q;
    assign bus.at_floor     = at_floor_q;
    assign bus.between      = between_q;
    assign bus.sensor_err   = sensor_err_q;
    assign bus.pending      = pending_q;
    assign bus.target       = target_q;
    assign bus.target_valid = target_valid_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.arrived      = arrived_q;

endmodule
